// File: rtl/edge_result_buf_pkg.sv
// Shared definitions for the edge-detection result buffer: OBI subordinate
// types, register offsets, STATUS/CTRL layouts and the user-domain demux rule.
// The optional STAT counter is enabled by defining EDGE_RESULT_BUF_STATS_EN.
package edge_result_buf_pkg;

    // OBI subordinate configuration used by the user-domain demux ports
    localparam int unsigned ObiAddrWidth = 32;
    localparam int unsigned ObiDataWidth = 32;
    localparam int unsigned ObiIdWidth   = 3;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t SbrObiCfg = '{
        AddrWidth: ObiAddrWidth,
        DataWidth: ObiDataWidth,
        IdWidth:   ObiIdWidth
    };

    typedef struct packed {
        logic [ObiAddrWidth-1:0]   addr;
        logic                      we;
        logic [ObiDataWidth/8-1:0] be;
        logic [ObiDataWidth-1:0]   wdata;
        logic [ObiIdWidth-1:0]     aid;
    } sbr_obi_a_chan_t;

    typedef struct packed {
        sbr_obi_a_chan_t a;
        logic            req;
    } sbr_obi_req_t;

    typedef struct packed {
        logic [ObiDataWidth-1:0] rdata;
        logic [ObiIdWidth-1:0]   rid;
        logic                    err;
    } sbr_obi_r_chan_t;

    typedef struct packed {
        sbr_obi_r_chan_t r;
        logic            gnt;
        logic            rvalid;
    } sbr_obi_rsp_t;

    // Register byte offsets inside the 4 KiB window
    localparam logic [7:0] EdgeBufDataOffset   = 8'h00;
    localparam logic [7:0] EdgeBufStatusOffset = 8'h04;
    localparam logic [7:0] EdgeBufCtrlOffset   = 8'h08;
    localparam logic [7:0] EdgeBufThreshOffset = 8'h0C;
    localparam logic [7:0] EdgeBufStatOffset   = 8'h10;

    // Read data returned alongside err=1
    localparam logic [31:0] EdgeBufErrData = 32'hBADCAB1E;

    typedef struct packed {
        logic [17:0] reserved;
        logic        underflow;
        logic        overflow;
        logic        done;
        logic        full;
        logic        empty;
        logic [8:0]  count;
    } edge_buf_status_t;

    typedef struct packed {
        logic [27:0] reserved;
        logic        clear;
        logic        irq_done_en;
        logic        irq_thresh_en;
        logic        en;
    } edge_buf_ctrl_t;

    // Position of this block on the user-domain OBI demux
    typedef struct packed {
        int unsigned idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_rule_t;

    localparam int unsigned UserEdgeBuf           = 1;
    localparam logic [31:0] UserEdgeBufAddrOffset = 32'h2000_1000;
    localparam logic [31:0] UserEdgeBufAddrRange  = 32'h0000_1000;

    localparam addr_rule_t UserEdgeBufAddrRule = '{
        idx:        UserEdgeBuf,
        start_addr: UserEdgeBufAddrOffset,
        end_addr:   UserEdgeBufAddrOffset + UserEdgeBufAddrRange
    };

endpackage

// File: rtl/edge_result_buf_fifo.sv
// Pixel FIFO for the edge result buffer: power-of-two depth, naturally
// wrapping pointers, explicit occupancy count, synchronous flush, and a
// registered pop-data output so the storage maps onto block RAM.
module edge_result_fifo #(
    parameter int unsigned Depth      = 16,
    parameter int unsigned PixelWidth = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic                      push_i,
    input  logic [PixelWidth-1:0]     data_i,
    input  logic                      pop_i,
    output logic [PixelWidth-1:0]     data_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(Depth):0]    count_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = AW + 1;

    logic [PixelWidth-1:0] mem_q [Depth];
    logic [PixelWidth-1:0] data_q;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  push_ok, pop_ok;

    assign full_o  = (count_q == CW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = data_q;

    // Flush overrides both ports; otherwise only legal pushes/pops take effect
    assign push_ok = push_i && !full_o  && !flush_i;
    assign pop_ok  = pop_i  && !empty_o && !flush_i;

    // Next pointer and occupancy values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Pointer and occupancy state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write port and registered read port (no reset on RAM contents)
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
        if (pop_ok)  data_q <= mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/edge_result_buf.sv
// Edge result buffer: accepts the accelerator pixel stream into a FIFO and
// exposes it to the core as an OBI subordinate with DATA/STATUS/CTRL/THRESH
// registers and a level interrupt.
// Define EDGE_RESULT_BUF_STATS_EN to add the STAT counter at offset 0x10.
module edge_result_buf
    import edge_result_buf_pkg::*;
#(
    parameter obi_cfg_t    ObiCfg     = SbrObiCfg,
    parameter type         obi_req_t  = sbr_obi_req_t,
    parameter type         obi_rsp_t  = sbr_obi_rsp_t,
    parameter int unsigned Depth      = 16,
    parameter int unsigned PixelWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  obi_req_t              obi_req_i,
    output obi_rsp_t              obi_rsp_o,
    input  logic                  px_valid_i,
    output logic                  px_ready_o,
    input  logic [PixelWidth-1:0] px_data_i,
    input  logic                  px_last_i,
    output logic                  irq_o
);

    localparam int unsigned DW = ObiCfg.DataWidth;
    localparam int unsigned IW = ObiCfg.IdWidth;
    localparam int unsigned CW = $clog2(Depth) + 1;

    // Control, flag and response state
    logic          en_q, en_d;
    logic          thresh_en_q, thresh_en_d;
    logic          done_en_q, done_en_d;
    logic [8:0]    thresh_q, thresh_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          irq_q, irq_d;
    logic          rvalid_q;
    logic [IW-1:0] rid_q;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          pop_rsp_q;

`ifdef EDGE_RESULT_BUF_STATS_EN
    logic [31:0]   stat_q, stat_d;
`endif

    // FIFO interface
    logic                  fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [PixelWidth-1:0] fifo_rdata;
    logic                  push, pop, clear;

    // Decode helpers
    logic                  req, we;
    logic                  addr_bad;
    logic [7:0]            reg_off;
    logic                  wr_ctrl, wr_thresh, unf_set;
    logic [DW-1:0]         pop_data;
    edge_buf_status_t      status;
    edge_buf_ctrl_t        ctrl_rd;
    logic                  unused_obi_bits;

    assign req = obi_req_i.req;
    assign we  = obi_req_i.a.we;
    assign reg_off = {3'b000, obi_req_i.a.addr[4:2], 2'b00};
`ifdef EDGE_RESULT_BUF_STATS_EN
    assign addr_bad = (obi_req_i.a.addr[11:5] != '0);
`else
    assign addr_bad = (obi_req_i.a.addr[11:4] != '0);
`endif

    assign unused_obi_bits = ^{obi_req_i.a.addr[31:12], obi_req_i.a.addr[1:0],
                               obi_req_i.a.wdata[31:9], obi_req_i.a.be[3:2]};

    // Readiness depends on registered state only
    assign px_ready_o = en_q && !fifo_full;
    assign push       = px_valid_i && px_ready_o;
    assign irq_o      = irq_q;

    edge_result_fifo #(
        .Depth      (Depth),
        .PixelWidth (PixelWidth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (clear),
        .push_i  (push),
        .data_i  (px_data_i),
        .pop_i   (pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Register readback words
    always_comb begin
        status           = '0;
        status.count     = 9'(fifo_count);
        status.empty     = fifo_empty;
        status.full      = fifo_full;
        status.done      = done_q;
        status.overflow  = ovf_q;
        status.underflow = unf_q;
        ctrl_rd               = '0;
        ctrl_rd.en            = en_q;
        ctrl_rd.irq_thresh_en = thresh_en_q;
        ctrl_rd.irq_done_en   = done_en_q;
        pop_data                 = '0;
        pop_data[PixelWidth-1:0] = fifo_rdata;
    end

    // OBI address decode; erroneous accesses raise no strobes
    always_comb begin
        rdata_d   = '0;
        err_d     = 1'b0;
        pop       = 1'b0;
        wr_ctrl   = 1'b0;
        wr_thresh = 1'b0;
        unf_set   = 1'b0;
        if (req) begin
            if (addr_bad) begin
                err_d = 1'b1;
            end else begin
                case (reg_off)
                    EdgeBufDataOffset: begin
                        if (we)              err_d   = 1'b1;
                        else if (fifo_empty) unf_set = 1'b1;
                        else                 pop     = 1'b1;
                    end
                    EdgeBufStatusOffset: begin
                        if (we) err_d = 1'b1;
                        else    rdata_d = DW'(status);
                    end
                    EdgeBufCtrlOffset: begin
                        if (we) wr_ctrl = 1'b1;
                        else    rdata_d = DW'(ctrl_rd);
                    end
                    EdgeBufThreshOffset: begin
                        if (we) wr_thresh = 1'b1;
                        else    rdata_d = DW'(thresh_q);
                    end
`ifdef EDGE_RESULT_BUF_STATS_EN
                    EdgeBufStatOffset: begin
                        if (we) err_d = 1'b1;
                        else    rdata_d = DW'(stat_q);
                    end
`endif
                    default: err_d = 1'b1;
                endcase
            end
        end
        if (err_d) rdata_d = DW'(EdgeBufErrData);
    end

    // Next control, threshold, flag and irq values; clear beats every set
    always_comb begin
        en_d        = en_q;
        thresh_en_d = thresh_en_q;
        done_en_d   = done_en_q;
        clear       = 1'b0;
        if (wr_ctrl && obi_req_i.a.be[0]) begin
            en_d        = obi_req_i.a.wdata[0];
            thresh_en_d = obi_req_i.a.wdata[1];
            done_en_d   = obi_req_i.a.wdata[2];
            clear       = obi_req_i.a.wdata[3];
        end
        thresh_d = thresh_q;
        if (wr_thresh) begin
            if (obi_req_i.a.be[0]) thresh_d[7:0] = obi_req_i.a.wdata[7:0];
            if (obi_req_i.a.be[1]) thresh_d[8]   = obi_req_i.a.wdata[8];
        end
        done_d = done_q || (push && px_last_i);
        ovf_d  = ovf_q  || (px_valid_i && en_q && fifo_full);
        unf_d  = unf_q  || unf_set;
`ifdef EDGE_RESULT_BUF_STATS_EN
        stat_d = stat_q;
        if (push && (32'(px_data_i) >= 32'(thresh_q[7:0])) && (stat_q != '1))
            stat_d = stat_q + 32'd1;
        if (clear) stat_d = '0;
`endif
        if (clear) begin
            done_d = 1'b0;
            ovf_d  = 1'b0;
            unf_d  = 1'b0;
        end
        irq_d = (thresh_en_q && (9'(fifo_count) >= thresh_q)) ||
                (done_en_q && done_q);
    end

    // State registers and the one-cycle OBI response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q        <= 1'b0;
            thresh_en_q <= 1'b0;
            done_en_q   <= 1'b0;
            thresh_q    <= 9'(Depth / 2);
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            irq_q       <= 1'b0;
            rvalid_q    <= 1'b0;
            rid_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            pop_rsp_q   <= 1'b0;
        end else begin
            en_q        <= en_d;
            thresh_en_q <= thresh_en_d;
            done_en_q   <= done_en_d;
            thresh_q    <= thresh_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            irq_q       <= irq_d;
            rvalid_q    <= req;
            rid_q       <= req ? obi_req_i.a.aid : '0;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            pop_rsp_q   <= pop;
        end
    end

`ifdef EDGE_RESULT_BUF_STATS_EN
    // Saturating count of accepted pixels at or above THRESH[7:0]
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stat_q <= '0;
        else         stat_q <= stat_d;
    end
`endif

    // Response assembly; popped data comes straight from the FIFO read register
    always_comb begin
        obi_rsp_o         = '0;
        obi_rsp_o.gnt     = req && rst_ni;
        obi_rsp_o.rvalid  = rvalid_q;
        obi_rsp_o.r.rdata = pop_rsp_q ? pop_data : rdata_q;
        obi_rsp_o.r.rid   = rid_q;
        obi_rsp_o.r.err   = err_q;
    end

endmodule

// File: tb/tb_edge_result_buf.sv
// Directed bench for edge_result_buf: OBI responses are checked by a
// scoreboard monitor; pixel-side and irq behaviour are checked inline.
`timescale 1ns/1ps
module tb_edge_result_buf;
    import edge_result_buf_pkg::*;

    logic         clk = 1'b0;
    logic         rst_ni;
    sbr_obi_req_t obi_req;
    sbr_obi_rsp_t obi_rsp;
    logic         px_valid, px_ready, px_last, irq;
    logic [7:0]   px_data;

    always #5 clk = ~clk;

    edge_result_buf #(
        .Depth      (16),
        .PixelWidth (8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .obi_req_i  (obi_req),
        .obi_rsp_o  (obi_rsp),
        .px_valid_i (px_valid),
        .px_ready_o (px_ready),
        .px_data_i  (px_data),
        .px_last_i  (px_last),
        .irq_o      (irq)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [2:0]  rid;
        string       name;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad   = 0;
    logic [2:0] next_id = 3'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end else begin
            $display("ok   %s value=0x%08h", name, act);
        end
    endtask

    // Scoreboard monitor: one expected entry per OBI response
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_ni && obi_rsp.rvalid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rvalid actual=rvalid required=no_response");
            end else begin
                e = exp_q.pop_front();
                if (obi_rsp.r.rdata !== e.rdata || obi_rsp.r.err !== e.err || obi_rsp.r.rid !== e.rid) begin
                    bad++;
                    $display("FAIL %s actual rdata=0x%08h err=%0b rid=%0d required rdata=0x%08h err=%0b rid=%0d",
                             e.name, obi_rsp.r.rdata, obi_rsp.r.err, obi_rsp.r.rid, e.rdata, e.err, e.rid);
                end else begin
                    $display("ok   %s rdata=0x%08h err=%0b rid=%0d", e.name, obi_rsp.r.rdata, obi_rsp.r.err, obi_rsp.r.rid);
                end
            end
        end
    end

    // Drive one request for the current cycle and queue its expected response
    task automatic obi_drive(input logic [31:0] addr, input logic we, input logic [3:0] be,
                             input logic [31:0] wdata, input logic [31:0] exp_rdata,
                             input logic exp_err, input string name);
        exp_t e;
        obi_req.req     = 1'b1;
        obi_req.a.addr  = addr;
        obi_req.a.we    = we;
        obi_req.a.be    = be;
        obi_req.a.wdata = wdata;
        obi_req.a.aid   = next_id;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.rid   = next_id;
        e.name  = name;
        exp_q.push_back(e);
        next_id = next_id + 3'd1;
        #1;
        check({name, "_gnt"}, 32'(obi_rsp.gnt), 32'd1);
    endtask

    task automatic obi_access(input logic [31:0] addr, input logic we, input logic [3:0] be,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_err, input string name);
        @(negedge clk);
        obi_drive(addr, we, be, wdata, exp_rdata, exp_err, name);
        @(negedge clk);
        obi_req.req = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_rdata, input string name);
        obi_access(addr, 1'b0, 4'h0, 32'h0, exp_rdata, 1'b0, name);
    endtask

    task automatic rd_err(input logic [31:0] addr, input string name);
        obi_access(addr, 1'b0, 4'h0, 32'h0, 32'hBADCAB1E, 1'b1, name);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata, input string name);
        obi_access(addr, 1'b1, be, wdata, 32'h0, 1'b0, name);
    endtask

    // Offer one pixel, waiting (bounded) for px_ready_o first
    task automatic push_px(input logic [7:0] data, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        while (!px_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $display("FAIL push_timeout actual=ready_low required=ready_high data=0x%02h", data);
        end
        px_valid = 1'b1;
        px_data  = data;
        px_last  = last;
        @(negedge clk);
        px_valid = 1'b0;
        px_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        obi_req  = '0;
        px_valid = 1'b0;
        px_data  = 8'h00;
        px_last  = 1'b0;
        rst_ni   = 1'b0;

        // Reset state, including gnt suppression while in reset
        repeat (2) @(negedge clk);
        obi_req.req = 1'b1;
        #1;
        check("reset_rsp_zero", 32'(obi_rsp == '0), 32'd1);
        check("reset_ready", 32'(px_ready), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        obi_req.req = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        rd(32'h4, 32'h0000_0200, "reset_status");
        rd(32'h8, 32'h0000_0000, "reset_ctrl");
        rd(32'hC, 32'h0000_0008, "reset_thresh");

        // Five pixels in, five out in order
        wr(32'h8, 4'hF, 32'h1, "ctrl_en");
        for (int i = 0; i < 5; i++) push_px(8'h10 + 8'(i), 1'b0);
        for (int i = 0; i < 5; i++) rd(32'h0, 32'h10 + i, $sformatf("data_in_order_%0d", i));
        rd(32'h4, 32'h0000_0200, "status_drained");

        // Burst of 17 with valid held: fill, then overflow on the 17th
        @(negedge clk);
        check("ready_before_burst", 32'(px_ready), 32'd1);
        px_valid = 1'b1;
        px_data  = 8'h20;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            px_data = 8'h20 + 8'(i);
        end
        check("ready_when_full", 32'(px_ready), 32'd0);
        @(negedge clk);
        px_valid = 1'b0;
        rd(32'h4, 32'h0000_1410, "status_full_overflow");
        for (int i = 0; i < 16; i++) rd(32'h0, 32'h20 + i, $sformatf("data_wrap_%0d", i));
        rd(32'h4, 32'h0000_1200, "status_empty_overflow");
        wr(32'h8, 4'hF, 32'h9, "ctrl_clear_1");
        rd(32'h4, 32'h0000_0200, "status_after_clear");
        rd(32'h8, 32'h0000_0001, "ctrl_clear_selfclears");

        // Threshold interrupt timing
        wr(32'hC, 4'hF, 32'h4, "thresh_4");
        wr(32'h8, 4'hF, 32'h3, "ctrl_thresh_irq");
        for (int i = 0; i < 4; i++) push_px(8'h30 + 8'(i), 1'b0);
        check("irq_thresh_not_early", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_thresh_rise", 32'(irq), 32'd1);
        rd(32'h0, 32'h30, "data_irq_pop");
        check("irq_thresh_hold", 32'(irq), 32'd1);
        @(negedge clk);
        check("irq_thresh_fall", 32'(irq), 32'd0);
        wr(32'h8, 4'hF, 32'h9, "ctrl_clear_2");

        // Underflow and error responses
        rd(32'h0, 32'h0, "data_empty_read");
        rd(32'h4, 32'h0000_2200, "status_underflow");
        obi_access(32'h4, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'hBADCAB1E, 1'b1, "status_write_err");
        rd(32'h4, 32'h0000_2200, "status_unchanged");
        obi_access(32'h0, 1'b1, 4'hF, 32'h0, 32'hBADCAB1E, 1'b1, "data_write_err");
        rd_err(32'h40, "addr_high_err");
        wr(32'h8, 4'h0, 32'h0, "ctrl_be0_noop");
        rd(32'h8, 32'h0000_0001, "ctrl_after_be0");
        wr(32'hC, 4'h2, 32'h1FF, "thresh_be1_only");
        rd(32'hC, 32'h0000_0104, "thresh_byte_enable");
        wr(32'hC, 4'hF, 32'h8, "thresh_restore");

        // Done interrupt, then clear racing a push
        wr(32'h8, 4'hF, 32'hD, "ctrl_done_irq_clear");
        push_px(8'h40, 1'b0);
        push_px(8'h41, 1'b0);
        push_px(8'h42, 1'b1);
        @(negedge clk);
        check("irq_done_rise", 32'(irq), 32'd1);
        rd(32'h4, 32'h0000_0803, "status_done");
        @(negedge clk);
        px_valid = 1'b1;
        px_data  = 8'h55;
        px_last  = 1'b1;
        obi_drive(32'h8, 1'b1, 4'hF, 32'hD, 32'h0, 1'b0, "ctrl_clear_with_push");
        @(negedge clk);
        px_valid    = 1'b0;
        px_last     = 1'b0;
        obi_req.req = 1'b0;
        @(negedge clk);
        check("irq_after_clear", 32'(irq), 32'd0);
        rd(32'h4, 32'h0000_0200, "status_clear_beats_push");

`ifdef EDGE_RESULT_BUF_STATS_EN
        // Pixel statistics against THRESH[7:0]
        wr(32'h8, 4'hF, 32'h9, "ctrl_clear_stat");
        wr(32'hC, 4'hF, 32'h80, "thresh_80");
        push_px(8'h7F, 1'b0);
        push_px(8'h80, 1'b0);
        push_px(8'hFF, 1'b0);
        rd(32'h10, 32'h2, "stat_count");
        rd_err(32'h14, "stat_gap_err");
        obi_access(32'h10, 1'b1, 4'hF, 32'h0, 32'hBADCAB1E, 1'b1, "stat_write_err");
`else
        rd_err(32'h10, "stat_absent_err");
`endif

        // Reset mid-frame discards everything
        push_px(8'h60, 1'b0);
        push_px(8'h61, 1'b0);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        check("midreset_ready", 32'(px_ready), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        rd(32'h4, 32'h0000_0200, "midreset_status");
        rd(32'h8, 32'h0000_0000, "midreset_ctrl");
        rd(32'hC, 32'h0000_0008, "midreset_thresh");

        // Let outstanding responses drain, bounded
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
